idex_hazard_stage: RTL and testbench
====================================

# idex_hazard_stage

ID/EX pipeline register with integrated load-use hazard detection for the 5-stage pipeline. Captures the decoded instruction from ID each cycle and presents register numbers, operands and control to EX and to the forwarding unit. Detects loads followed by a dependent instruction, inserts a one-cycle bubble and freezes PC and IF/ID. Also applies branch flush and external memory stall.

## Interface
- No parameters; all widths fixed.
- clk  in  1  pipeline clock, rising edge
- reset  in  1  synchronous, active-high
- id_valid  in  1  ID holds a real instruction
- id_rs / id_rt / id_rd  in  5 each  decoded register numbers
- id_uses_rt  in  1  instruction reads rt as a source (R-type, store, beq)
- id_data1 / id_data2  in  32 each  register-file read data
- id_imm  in  32  sign-extended immediate
- id_ctrl  in  8  {RegWrite, MemtoReg, MemRead, MemWrite, Branch, ALUSrc, RegDst, spare} (bit 7 first)
- id_aluop  in  2  ALU operation class
- flush  in  1  branch taken in EX; squash ID/EX contents
- ext_stall  in  1  memory busy; freeze the whole front end
- ex_valid  out  1  ID/EX holds a real instruction
- ex_rs / ex_rt / ex_rd  out  5 each  to EX and forwarding unit
- ex_data1 / ex_data2 / ex_imm  out  32 each
- ex_ctrl  out  8; ex_aluop  out  2
- pc_write  out  1  PC may update
- ifid_write  out  1  IF/ID may update
- hazard  out  1  load-use bubble inserted this cycle
- stall_cycles  out  16  only with IDEX_STALL_CNT_EN

## Operation
- Load-use condition: hazard = id_valid & ex_valid & ex_ctrl[MemRead] & (ex_rt != 0) & ((ex_rt == id_rs) | (id_uses_rt & ex_rt == id_rt)). Combinational.
- pc_write = ifid_write = ~(hazard | ext_stall) & ~reset.
- Register update priority on each rising edge:
  - reset: clear all outputs.
  - flush: clear ex_valid, ex_ctrl, ex_aluop. Datapath fields may take any value.
  - ext_stall: hold every register.
  - hazard: load a bubble. ex_valid = 0, ex_ctrl = 0, ex_aluop = 0. Register numbers are cleared to 0 so forwarding never matches.
  - Otherwise: load all id_* fields. ex_valid = id_valid. ex_ctrl and ex_aluop are forced to 0 when id_valid = 0.
- A bubble ex_ctrl has RegWrite = 0 and MemRead = 0. The cycle after a bubble therefore cannot raise hazard again for the same pair, so a load-use stall lasts exactly one cycle.
- flush takes priority over ext_stall and over hazard. The squashed instruction never reaches EX.
- Register 0 never raises a hazard.

## Timing
- ID to EX latency: 1 cycle.
- hazard, pc_write and ifid_write are combinational on the current ID/EX and ID contents.
- Reset values: ex_valid 0, ex_rs/rt/rd 0, ex_data1/data2/imm 0, ex_ctrl 0, ex_aluop 0, stall_cycles 0.
- pc_write and ifid_write are 0 while reset is high.
- Reset mid-stall: the next cycle shows an empty ID/EX with hazard = 0.
- Simultaneous flush and hazard: flush wins. The bubble and flush results are identical (ex_valid 0); pc_write is still 0 that cycle.
- ext_stall with hazard: hold; hazard stays asserted until ext_stall drops, then one bubble is inserted.

## Configuration
- IDEX_STALL_CNT_EN defined:
  - stall_cycles increments by 1 on every edge where hazard | ext_stall and reset is low.
  - Saturates at 16'hFFFF, no wrap.
  - Clears on reset.
- Undefined: stall_cycles port and counter are absent; nothing else changes.

## Test plan
- Reset, then ID = valid R-type rs=1 rt=2 rd=3, data1=0x11 -> next cycle ex_rs=1, ex_rt=2, ex_rd=3, ex_data1=0x11, ex_valid=1, hazard=0.
- lw rt=5 in EX, add rs=5 in ID -> hazard=1, pc_write=0, ifid_write=0. Next cycle ex_valid=0, ex_ctrl=0, hazard=0. The following cycle the add reaches EX with ex_rs=5.
- lw rt=0 in EX, ID rs=0 -> hazard=0. lw rt=6 in EX, ID addi rt=6 with id_uses_rt=0 -> hazard=0.
- flush=1 together with hazard=1 and valid ID -> next cycle ex_valid=0, ex_ctrl=0.
- ext_stall held 3 cycles with a valid instruction in ID/EX -> outputs unchanged for 3 cycles, pc_write=0 throughout. With IDEX_STALL_CNT_EN, stall_cycles=3.
- IDEX_STALL_CNT_EN with stall_cycles preloaded near 0xFFFF by sustained ext_stall -> holds 0xFFFF; reset -> 0.

Source files
------------

// File: rtl/idex_hazard_stage.sv
// idex_hazard_stage: ID/EX pipeline register with load-use hazard detection.
// Captures the decoded instruction each cycle, inserts a one-cycle bubble
// when a load in EX feeds the instruction in ID, and applies branch flush
// and external memory stall.
// Optional feature macro: IDEX_STALL_CNT_EN adds a saturating 16-bit
// stall_cycles counter output (hazard or ext_stall cycles).
module idex_hazard_stage (
  input  logic        clk,
  input  logic        reset,
  input  logic        id_valid,
  input  logic [4:0]  id_rs,
  input  logic [4:0]  id_rt,
  input  logic [4:0]  id_rd,
  input  logic        id_uses_rt,
  input  logic [31:0] id_data1,
  input  logic [31:0] id_data2,
  input  logic [31:0] id_imm,
  input  logic [7:0]  id_ctrl,
  input  logic [1:0]  id_aluop,
  input  logic        flush,
  input  logic        ext_stall,
  output logic        ex_valid,
  output logic [4:0]  ex_rs,
  output logic [4:0]  ex_rt,
  output logic [4:0]  ex_rd,
  output logic [31:0] ex_data1,
  output logic [31:0] ex_data2,
  output logic [31:0] ex_imm,
  output logic [7:0]  ex_ctrl,
  output logic [1:0]  ex_aluop,
  output logic        pc_write,
  output logic        ifid_write,
`ifdef IDEX_STALL_CNT_EN
  output logic [15:0] stall_cycles,
`endif
  output logic        hazard
);

  // id_ctrl bit positions: {RegWrite, MemtoReg, MemRead, MemWrite, Branch, ALUSrc, RegDst, spare}
  localparam int unsigned MEMREAD_BIT = 5;

  logic        r_ex_valid;
  logic [4:0]  r_ex_rs;
  logic [4:0]  r_ex_rt;
  logic [4:0]  r_ex_rd;
  logic [31:0] r_ex_data1;
  logic [31:0] r_ex_data2;
  logic [31:0] r_ex_imm;
  logic [7:0]  r_ex_ctrl;
  logic [1:0]  r_ex_aluop;
  logic        w_hazard;
  logic        w_rt_match;
  logic        w_front_write;

  // Load-use detection: a valid load in EX whose nonzero rt is a source of ID.
  always_comb begin
    w_rt_match = 1'b0;
    w_hazard   = 1'b0;
    if (id_uses_rt && (r_ex_rt == id_rt)) begin
      w_rt_match = 1'b1;
    end else begin
      w_rt_match = 1'b0;
    end
    if (id_valid && r_ex_valid && r_ex_ctrl[MEMREAD_BIT] && (r_ex_rt != 5'd0) &&
        ((r_ex_rt == id_rs) || w_rt_match)) begin
      w_hazard = 1'b1;
    end else begin
      w_hazard = 1'b0;
    end
  end

  // Front end may advance only when neither a bubble nor a memory stall is pending.
  always_comb begin
    w_front_write = 1'b0;
    if (reset || w_hazard || ext_stall) begin
      w_front_write = 1'b0;
    end else begin
      w_front_write = 1'b1;
    end
  end

  // ID/EX register update: reset > flush > ext_stall > bubble > normal load.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_ex_valid <= 1'b0;
      r_ex_rs    <= 5'd0;
      r_ex_rt    <= 5'd0;
      r_ex_rd    <= 5'd0;
      r_ex_data1 <= 32'd0;
      r_ex_data2 <= 32'd0;
      r_ex_imm   <= 32'd0;
      r_ex_ctrl  <= 8'd0;
      r_ex_aluop <= 2'd0;
    end else if (flush) begin
      // Squash only the control side; datapath fields are don't-care while invalid.
      r_ex_valid <= 1'b0;
      r_ex_ctrl  <= 8'd0;
      r_ex_aluop <= 2'd0;
    end else if (ext_stall) begin
      r_ex_valid <= r_ex_valid;
    end else if (w_hazard) begin
      // Bubble: zero register numbers so the forwarding unit never matches it.
      r_ex_valid <= 1'b0;
      r_ex_rs    <= 5'd0;
      r_ex_rt    <= 5'd0;
      r_ex_rd    <= 5'd0;
      r_ex_ctrl  <= 8'd0;
      r_ex_aluop <= 2'd0;
    end else begin
      r_ex_valid <= id_valid;
      r_ex_rs    <= id_rs;
      r_ex_rt    <= id_rt;
      r_ex_rd    <= id_rd;
      r_ex_data1 <= id_data1;
      r_ex_data2 <= id_data2;
      r_ex_imm   <= id_imm;
      r_ex_ctrl  <= id_valid ? id_ctrl  : 8'd0;
      r_ex_aluop <= id_valid ? id_aluop : 2'd0;
    end
  end

`ifdef IDEX_STALL_CNT_EN
  logic [15:0] r_stall_cycles;

  // Saturating count of cycles in which the front end was frozen.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_stall_cycles <= 16'd0;
    end else if ((w_hazard || ext_stall) && (r_stall_cycles != 16'hFFFF)) begin
      r_stall_cycles <= r_stall_cycles + 16'd1;
    end else begin
      r_stall_cycles <= r_stall_cycles;
    end
  end

  assign stall_cycles = r_stall_cycles;
`endif

  assign ex_valid   = r_ex_valid;
  assign ex_rs      = r_ex_rs;
  assign ex_rt      = r_ex_rt;
  assign ex_rd      = r_ex_rd;
  assign ex_data1   = r_ex_data1;
  assign ex_data2   = r_ex_data2;
  assign ex_imm     = r_ex_imm;
  assign ex_ctrl    = r_ex_ctrl;
  assign ex_aluop   = r_ex_aluop;
  assign hazard     = w_hazard;
  assign pc_write   = w_front_write;
  assign ifid_write = w_front_write;

endmodule

// File: tb/tb_idex_hazard_stage.sv
// Scoreboard bench for idex_hazard_stage: a driver applies directed and
// random ID-stage traffic on the falling edge and queues the expected
// outputs from a reference model; a monitor pops and compares each cycle.
module tb_idex_hazard_stage;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        id_valid = 1'b0;
  logic [4:0]  id_rs = 5'd0, id_rt = 5'd0, id_rd = 5'd0;
  logic        id_uses_rt = 1'b0;
  logic [31:0] id_data1 = 32'd0, id_data2 = 32'd0, id_imm = 32'd0;
  logic [7:0]  id_ctrl = 8'd0;
  logic [1:0]  id_aluop = 2'd0;
  logic        flush = 1'b0, ext_stall = 1'b0;
  logic        ex_valid, pc_write, ifid_write, hazard;
  logic [4:0]  ex_rs, ex_rt, ex_rd;
  logic [31:0] ex_data1, ex_data2, ex_imm;
  logic [7:0]  ex_ctrl;
  logic [1:0]  ex_aluop;
  logic [15:0] stall_cycles;

  idex_hazard_stage dut (
    .clk(clk), .reset(reset), .id_valid(id_valid),
    .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd), .id_uses_rt(id_uses_rt),
    .id_data1(id_data1), .id_data2(id_data2), .id_imm(id_imm),
    .id_ctrl(id_ctrl), .id_aluop(id_aluop), .flush(flush), .ext_stall(ext_stall),
    .ex_valid(ex_valid), .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_rd(ex_rd),
    .ex_data1(ex_data1), .ex_data2(ex_data2), .ex_imm(ex_imm),
    .ex_ctrl(ex_ctrl), .ex_aluop(ex_aluop), .pc_write(pc_write),
    .ifid_write(ifid_write),
`ifdef IDEX_STALL_CNT_EN
    .stall_cycles(stall_cycles),
`endif
    .hazard(hazard)
  );

`ifndef IDEX_STALL_CNT_EN
  assign stall_cycles = 16'd0;
`endif

  always #5 clk = ~clk;

  // Contents of the EX slot as the model sees it, plus what the outputs must show.
  typedef struct {
    logic        valid;
    logic [4:0]  rs, rt, rd;
    logic [31:0] d1, d2, imm;
    logic [7:0]  ctrl;
    logic [1:0]  aluop;
    logic        regs_known, data_known;
    logic        hz, pcw;
    logic [15:0] cnt;
    int          cyc;
  } exp_t;

  exp_t m;          // model EX slot
  logic [15:0] m_cnt;
  exp_t q[$];
  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;

  localparam logic [7:0] C_RTYPE = 8'b1000_0010;
  localparam logic [7:0] C_LW    = 8'b1110_0100;
  localparam logic [7:0] C_ADDI  = 8'b1000_0100;

  // Load-use rule: EX holds a valid load writing a nonzero rt that ID reads.
  function automatic logic ref_hazard(exp_t s, logic v, logic [4:0] rs, logic [4:0] rt, logic ut);
    logic [4:0] srcs[$];
    if (!v || !s.valid || !s.ctrl[5] || s.rt == 5'd0) return 1'b0;
    srcs.push_back(rs);
    if (ut) srcs.push_back(rt);
    foreach (srcs[i]) if (srcs[i] == s.rt) return 1'b1;
    return 1'b0;
  endfunction

  task automatic step(input logic rst, input logic v, input logic [4:0] rs, input logic [4:0] rt,
                      input logic [4:0] rd, input logic ut, input logic [31:0] d1,
                      input logic [31:0] d2, input logic [31:0] imm, input logic [7:0] ctrl,
                      input logic [1:0] aluop, input logic fl, input logic st);
    exp_t e;
    logic hz;
    @(negedge clk);
    cyc++;
    reset = rst; id_valid = v; id_rs = rs; id_rt = rt; id_rd = rd; id_uses_rt = ut;
    id_data1 = d1; id_data2 = d2; id_imm = imm; id_ctrl = ctrl; id_aluop = aluop;
    flush = fl; ext_stall = st;
    hz = ref_hazard(m, v, rs, rt, ut);
    e = m;
    e.hz = hz;
    e.pcw = !(hz || st || rst);
    e.cnt = m_cnt;
    e.cyc = cyc;
    q.push_back(e);
    // Advance the model to what the EX slot holds after this edge.
    if (rst) begin
      m = '{default: '0};
      m.regs_known = 1'b1; m.data_known = 1'b1;
      m_cnt = 16'd0;
    end else begin
      if ((hz || st) && m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
      if (fl) begin
        m.valid = 1'b0; m.ctrl = 8'd0; m.aluop = 2'd0;
        m.regs_known = 1'b0; m.data_known = 1'b0;
      end else if (st) begin
        m = m;
      end else if (hz) begin
        m.valid = 1'b0; m.ctrl = 8'd0; m.aluop = 2'd0;
        m.rs = 5'd0; m.rt = 5'd0; m.rd = 5'd0;
        m.regs_known = 1'b1; m.data_known = 1'b0;
      end else begin
        m.valid = v; m.rs = rs; m.rt = rt; m.rd = rd;
        m.d1 = d1; m.d2 = d2; m.imm = imm;
        m.ctrl = v ? ctrl : 8'd0; m.aluop = v ? aluop : 2'd0;
        m.regs_known = 1'b1; m.data_known = 1'b1;
      end
    end
  endtask

  task automatic ins(input logic v, input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
                     input logic ut, input logic [31:0] d1, input logic [7:0] ctrl,
                     input logic fl, input logic st);
    step(1'b0, v, rs, rt, rd, ut, d1, d1 ^ 32'h5A5A_0000, d1 + 32'd4, ctrl, 2'b10, fl, st);
  endtask

  task automatic chk(input string name, input int c, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s cycle=%0d got=%h expected=%h", name, c, got, exp);
    end
  endtask

  // Monitor: every cycle the DUT presents its outputs; compare against the queue head.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("ex_valid", e.cyc, 32'(ex_valid), 32'(e.valid));
        chk("ex_ctrl", e.cyc, 32'(ex_ctrl), 32'(e.ctrl));
        chk("ex_aluop", e.cyc, 32'(ex_aluop), 32'(e.aluop));
        chk("hazard", e.cyc, 32'(hazard), 32'(e.hz));
        chk("pc_write", e.cyc, 32'(pc_write), 32'(e.pcw));
        chk("ifid_write", e.cyc, 32'(ifid_write), 32'(e.pcw));
        if (e.regs_known) begin
          chk("ex_rs", e.cyc, 32'(ex_rs), 32'(e.rs));
          chk("ex_rt", e.cyc, 32'(ex_rt), 32'(e.rt));
          chk("ex_rd", e.cyc, 32'(ex_rd), 32'(e.rd));
        end
        if (e.data_known) begin
          chk("ex_data1", e.cyc, ex_data1, e.d1);
          chk("ex_data2", e.cyc, ex_data2, e.d2);
          chk("ex_imm", e.cyc, ex_imm, e.imm);
        end
`ifdef IDEX_STALL_CNT_EN
        chk("stall_cycles", e.cyc, 32'(stall_cycles), 32'(e.cnt));
`endif
      end
    end
  end

  initial begin
    int wait_cycles;
    m = '{default: '0};
    m_cnt = 16'd0;
    // Reset, then an R-type rs=1 rt=2 rd=3 data1=0x11.
    step(1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 32'd0, 32'd0, 32'd0, 8'd0, 2'd0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 32'd0, 32'd0, 32'd0, 8'd0, 2'd0, 1'b0, 1'b0);
    ins(1'b1, 5'd1, 5'd2, 5'd3, 1'b1, 32'h11, C_RTYPE, 1'b0, 1'b0);
    // lw rt=5 then dependent add rs=5: bubble, then the add enters EX.
    ins(1'b1, 5'd1, 5'd5, 5'd0, 1'b0, 32'h100, C_LW, 1'b0, 1'b0);
    ins(1'b1, 5'd5, 5'd2, 5'd9, 1'b1, 32'h200, C_RTYPE, 1'b0, 1'b0);
    ins(1'b1, 5'd5, 5'd2, 5'd9, 1'b1, 32'h200, C_RTYPE, 1'b0, 1'b0);
    ins(1'b1, 5'd3, 5'd4, 5'd10, 1'b1, 32'h300, C_RTYPE, 1'b0, 1'b0);
    // lw rt=0 with ID rs=0; lw rt=6 with addi rt=6 not read.
    ins(1'b1, 5'd1, 5'd0, 5'd0, 1'b0, 32'h400, C_LW, 1'b0, 1'b0);
    ins(1'b1, 5'd0, 5'd0, 5'd8, 1'b1, 32'h500, C_RTYPE, 1'b0, 1'b0);
    ins(1'b1, 5'd1, 5'd6, 5'd0, 1'b0, 32'h600, C_LW, 1'b0, 1'b0);
    ins(1'b1, 5'd1, 5'd6, 5'd0, 1'b0, 32'h700, C_ADDI, 1'b0, 1'b0);
    // Load-use through rt, then flush together with a hazard.
    ins(1'b1, 5'd2, 5'd7, 5'd0, 1'b0, 32'h800, C_LW, 1'b0, 1'b0);
    ins(1'b1, 5'd1, 5'd7, 5'd11, 1'b1, 32'h900, C_RTYPE, 1'b0, 1'b0);
    ins(1'b1, 5'd2, 5'd7, 5'd0, 1'b0, 32'hA00, C_LW, 1'b0, 1'b0);
    ins(1'b1, 5'd7, 5'd1, 5'd12, 1'b1, 32'hB00, C_RTYPE, 1'b1, 1'b0);
    // ext_stall for 3 cycles from reset with a valid instruction in EX.
    step(1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 32'd0, 32'd0, 32'd0, 8'd0, 2'd0, 1'b0, 1'b0);
    ins(1'b1, 5'd4, 5'd5, 5'd6, 1'b1, 32'hC00, C_RTYPE, 1'b0, 1'b0);
    repeat (3) ins(1'b1, 5'd9, 5'd9, 5'd9, 1'b1, 32'hD00, C_RTYPE, 1'b0, 1'b1);
    ins(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 32'hE00, C_RTYPE, 1'b0, 1'b0);
    // ext_stall together with a hazard, then release; then reset mid-stall.
    ins(1'b1, 5'd1, 5'd8, 5'd0, 1'b0, 32'hF00, C_LW, 1'b0, 1'b0);
    repeat (2) ins(1'b1, 5'd8, 5'd1, 5'd2, 1'b1, 32'h1000, C_RTYPE, 1'b0, 1'b1);
    ins(1'b1, 5'd8, 5'd1, 5'd2, 1'b1, 32'h1000, C_RTYPE, 1'b0, 1'b0);
    ins(1'b1, 5'd8, 5'd1, 5'd2, 1'b1, 32'h1000, C_RTYPE, 1'b0, 1'b0);
    ins(1'b1, 5'd1, 5'd3, 5'd0, 1'b0, 32'h1100, C_LW, 1'b0, 1'b0);
    step(1'b1, 1'b1, 5'd3, 5'd0, 5'd4, 1'b1, 32'd1, 32'd2, 32'd3, C_RTYPE, 2'd2, 1'b0, 1'b0);
    ins(1'b1, 5'd3, 5'd0, 5'd4, 1'b1, 32'h1200, C_RTYPE, 1'b0, 1'b0);
    // Random traffic with small register numbers so hazards are frequent.
    for (int i = 0; i < 2000; i++) begin
      step(($urandom_range(0, 99) < 2), ($urandom_range(0, 9) < 8),
           5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 31)),
           1'($urandom), $urandom, $urandom, $urandom, 8'($urandom), 2'($urandom),
           ($urandom_range(0, 99) < 8), ($urandom_range(0, 99) < 12));
    end
`ifdef IDEX_STALL_CNT_EN
    // Drive the counter into saturation, then reset it.
    repeat (65540) ins(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 32'd0, 8'd0, 1'b0, 1'b1);
    step(1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 32'd0, 32'd0, 32'd0, 8'd0, 2'd0, 1'b0, 1'b0);
    ins(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 32'd0, 8'd0, 1'b0, 1'b0);
`endif
    wait_cycles = 0;
    while (q.size() > 0 && wait_cycles < 10) begin
      @(negedge clk);
      wait_cycles++;
    end
    #2;
    if (q.size() > 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL drain pending=%0d expected=0", q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
